// File: rtl/tl_pkg.sv
// Shared encodings for the traffic-light lamp monitor: lamp bit positions,
// phase output encoding, fault codes and the checker FSM state type.
package tl_pkg;

   localparam int LAMP_R = 2;
   localparam int LAMP_Y = 1;
   localparam int LAMP_G = 0;

   localparam logic [2:0] LAMPS_RED    = 3'b100;
   localparam logic [2:0] LAMPS_YELLOW = 3'b010;
   localparam logic [2:0] LAMPS_GREEN  = 3'b001;

   localparam logic [1:0] PH_UNKNOWN = 2'b00;
   localparam logic [1:0] PH_RED     = 2'b01;
   localparam logic [1:0] PH_YELLOW  = 2'b10;
   localparam logic [1:0] PH_GREEN   = 2'b11;

   localparam logic [2:0] FC_NONE        = 3'd0;
   localparam logic [2:0] FC_MULTI_LAMP  = 3'd1;
   localparam logic [2:0] FC_DARK        = 3'd2;
   localparam logic [2:0] FC_BAD_SEQ     = 3'd3;
   localparam logic [2:0] FC_SHORT_DWELL = 3'd4;
   localparam logic [2:0] FC_LONG_DWELL  = 3'd5;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_RED,
      ST_YELLOW,
      ST_GREEN,
      ST_FAULT
   } tl_state_e;

   // Non one-hot patterns map to ST_INIT; callers screen them out first.
   function automatic tl_state_e lamp_to_state(input logic [2:0] lamps);
      tl_state_e s;
      case (lamps)
         LAMPS_RED:    s = ST_RED;
         LAMPS_YELLOW: s = ST_YELLOW;
         LAMPS_GREEN:  s = ST_GREEN;
         default:      s = ST_INIT;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] state_to_phase(input tl_state_e s);
      logic [1:0] p;
      case (s)
         ST_RED:    p = PH_RED;
         ST_YELLOW: p = PH_YELLOW;
         ST_GREEN:  p = PH_GREEN;
         default:   p = PH_UNKNOWN;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Saturating per-phase dwell counter with minimum / maximum comparators.
// i_load restarts the count at i_load_val (1 on a normal phase entry).
module tl_dwell_timer #(
   parameter int CNT_W     = 8,
   parameter int MAX_DWELL = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic [CNT_W-1:0] i_min,
   output logic             o_below_min,
   output logic             o_at_max
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DWELL);

   logic [CNT_W-1:0] r_dwell;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dwell <= '0;
      end else if (i_load) begin
         r_dwell <= i_load_val;
      end else if (r_dwell != '1) begin
         r_dwell <= r_dwell + 1'b1;
      end
   end

   assign o_below_min = (r_dwell < i_min);
   assign o_at_max    = (r_dwell >= MAX_C);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker for traffic_light: registers the lamps, tracks
// phase/dwell and latches the highest-priority violation as a sticky fault.
// Optional build macro TL_MON_AUTOCLEAR_EN: leave FAULT after MIN_RED clean red cycles.
module traffic_light_monitor
   import tl_pkg::*;
#(
   parameter int MIN_GREEN  = 4,
   parameter int YELLOW_MIN = 2,
   parameter int MIN_RED    = 4,
   parameter int MAX_DWELL  = 64,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   input  logic             emergency,
   input  logic             clear_fault,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [CNT_W-1:0] MIN_G_C = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(YELLOW_MIN);
   localparam logic [CNT_W-1:0] MIN_R_C = CNT_W'(MIN_RED);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [2:0]       r_lamp_q;
   logic             r_emerg_q;
   tl_state_e        r_state;
   logic             r_fault;
   logic [2:0]       r_fault_code;
   logic [CNT_W-1:0] r_cycle_count;

   tl_state_e        w_state_nxt;
   tl_state_e        w_lamp_state;
   logic             w_fault_nxt;
   logic [2:0]       w_code_nxt;
   logic [2:0]       w_viol;
   logic             w_cc_inc;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_min;
   logic             w_below_min;
   logic             w_at_max;
   logic             w_multi;
   logic             w_dark;
   logic             w_legal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lamp_q  <= '0;
         r_emerg_q <= 1'b0;
      end else begin
         r_lamp_q[LAMP_R] <= red;
         r_lamp_q[LAMP_Y] <= yellow;
         r_lamp_q[LAMP_G] <= green;
         r_emerg_q        <= emergency;
      end
   end

   always_comb begin
      w_min = '0;
      case (r_state)
         ST_GREEN:  w_min = MIN_G_C;
         ST_YELLOW: w_min = MIN_Y_C;
         ST_RED:    w_min = MIN_R_C;
         default:   w_min = '0;
      endcase
   end

   tl_dwell_timer #(
      .CNT_W     (CNT_W),
      .MAX_DWELL (MAX_DWELL)
   ) u_dwell (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_load_val  (w_load_val),
      .i_min       (w_min),
      .o_below_min (w_below_min),
      .o_at_max    (w_at_max)
   );

`ifdef TL_MON_AUTOCLEAR_EN
   localparam logic [CNT_W-1:0] CLEAN_LAST = CNT_W'(MIN_RED - 1);
   logic [CNT_W-1:0] r_clean;

   // Consecutive clean red-only samples seen while parked in FAULT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clean <= '0;
      end else if (r_state == ST_FAULT && r_lamp_q == LAMPS_RED && !clear_fault) begin
         r_clean <= r_clean + 1'b1;
      end else begin
         r_clean <= '0;
      end
   end
`endif

   always_comb begin
      w_multi      = ((r_lamp_q & (r_lamp_q - 3'b001)) != 3'b000);
      w_dark       = (r_lamp_q == 3'b000);
      w_lamp_state = lamp_to_state(r_lamp_q);
      w_legal      = (r_state == ST_GREEN  && w_lamp_state == ST_YELLOW) ||
                     (r_state == ST_YELLOW && w_lamp_state == ST_RED)    ||
                     (r_state == ST_RED    && w_lamp_state == ST_GREEN)  ||
                     (r_state == ST_GREEN  && w_lamp_state == ST_RED && r_emerg_q);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fault_nxt = r_fault;
      w_code_nxt  = r_fault_code;
      w_viol      = FC_NONE;
      w_cc_inc    = 1'b0;
      w_load      = 1'b0;
      w_load_val  = ONE_C;
      case (r_state)
         ST_INIT: begin
            if (w_multi) begin
               w_viol = FC_MULTI_LAMP;
            end else if (!w_dark) begin
               w_state_nxt = w_lamp_state;
               w_load      = 1'b1;
            end
         end
         ST_RED, ST_YELLOW, ST_GREEN: begin
            if (w_multi) begin
               w_viol = FC_MULTI_LAMP;
            end else if (w_dark) begin
               w_viol = FC_DARK;
            end else if (w_lamp_state == r_state) begin
               if (w_at_max && !(r_state == ST_RED && r_emerg_q))
                  w_viol = FC_LONG_DWELL;
            end else if (!w_legal) begin
               w_viol = FC_BAD_SEQ;
            end else if (w_below_min && !r_emerg_q) begin
               w_viol = FC_SHORT_DWELL;
            end else begin
               w_state_nxt = w_lamp_state;
               w_load      = 1'b1;
               w_cc_inc    = (r_state == ST_RED);
            end
         end
         default: begin
`ifdef TL_MON_AUTOCLEAR_EN
            if (r_lamp_q == LAMPS_RED && r_clean == CLEAN_LAST) begin
               w_state_nxt = ST_RED;
               w_fault_nxt = 1'b0;
               w_load      = 1'b1;
               w_load_val  = MIN_R_C;
            end
`endif
         end
      endcase
      if (w_viol != FC_NONE) begin
         w_state_nxt = ST_FAULT;
         w_fault_nxt = 1'b1;
         w_code_nxt  = w_viol;
      end
      // A clear in the same cycle as a new violation wins; a persisting one
      // is picked up again from INIT.
      if (clear_fault) begin
         w_state_nxt = ST_INIT;
         w_fault_nxt = 1'b0;
         w_code_nxt  = FC_NONE;
         w_cc_inc    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_INIT;
         r_fault       <= 1'b0;
         r_fault_code  <= FC_NONE;
         r_cycle_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_fault      <= w_fault_nxt;
         r_fault_code <= w_code_nxt;
         if (w_cc_inc)
            r_cycle_count <= r_cycle_count + 1'b1;
      end
   end

   always_comb begin
      phase       = state_to_phase(r_state);
      fault       = r_fault;
      fault_code  = r_fault_code;
      cycle_count = r_cycle_count;
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a vector table for lamp-pattern
// faults and clears, plus hand sequences for dwell timing and async reset.
module tb_traffic_light_monitor;

   localparam logic [2:0] L_DK = 3'b000;
   localparam logic [2:0] L_R  = 3'b100;
   localparam logic [2:0] L_Y  = 3'b010;
   localparam logic [2:0] L_G  = 3'b001;
   localparam logic [2:0] L_GY = 3'b011;
   localparam logic [2:0] L_RG = 3'b101;

   localparam logic [1:0] P_U = 2'b00;
   localparam logic [1:0] P_R = 2'b01;
   localparam logic [1:0] P_Y = 2'b10;
   localparam logic [1:0] P_G = 2'b11;

   typedef struct {
      logic [2:0] lamps;
      logic       clr;
      logic       f;
      logic [2:0] code;
      logic [1:0] ph;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
   logic       emergency = 1'b0;
   logic       clear_fault = 1'b0;
   logic       fault;
   logic [2:0] fault_code;
   logic [1:0] phase;
   logic [7:0] cycle_count;

   int n_chk  = 0;
   int n_fail = 0;

   traffic_light_monitor dut (
      .clk         (clk),
      .reset       (reset),
      .red         (red),
      .yellow      (yellow),
      .green       (green),
      .emergency   (emergency),
      .clear_fault (clear_fault),
      .fault       (fault),
      .fault_code  (fault_code),
      .phase       (phase),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] l, input logic e, input logic c);
      {red, yellow, green} = l;
      emergency   = e;
      clear_fault = c;
   endtask

   task automatic run(input logic [2:0] l, input logic e, input int n);
      for (int i = 0; i < n; i++) begin
         drive(l, e, 1'b0);
         tick();
      end
   endtask

   task automatic do_reset();
      drive(L_DK, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic chk(input string nm, input logic ef, input logic [2:0] ec, input logic [1:0] ep);
      n_chk++;
      if (fault !== ef || fault_code !== ec || phase !== ep) begin
         n_fail++;
         $display("FAIL %s: got fault=%0b code=%0d phase=%0d, want fault=%0b code=%0d phase=%0d",
                  nm, fault, fault_code, phase, ef, ec, ep);
      end
   endtask

   task automatic chk_cc(input string nm, input logic [7:0] ecc);
      n_chk++;
      if (cycle_count !== ecc) begin
         n_fail++;
         $display("FAIL %s: got cycle_count=%0d, want %0d", nm, cycle_count, ecc);
      end
   endtask

   function automatic logic [1:0] ph_of(input logic [2:0] l);
      case (l)
         L_R:     return P_R;
         L_Y:     return P_Y;
         L_G:     return P_G;
         default: return P_U;
      endcase
   endfunction

   vec_t tbl[22];

   initial begin
      logic [2:0] prev;
      logic [2:0] sched[4];
      int         len[4];

      tbl[0]  = '{L_DK, 1'b0, 1'b0, 3'd0, P_U};
      tbl[1]  = '{L_G,  1'b0, 1'b0, 3'd0, P_U};
      tbl[2]  = '{L_G,  1'b0, 1'b0, 3'd0, P_G};
      tbl[3]  = '{L_G,  1'b0, 1'b0, 3'd0, P_G};
      tbl[4]  = '{L_GY, 1'b0, 1'b0, 3'd0, P_G};
      tbl[5]  = '{L_G,  1'b0, 1'b1, 3'd1, P_U};
      tbl[6]  = '{L_G,  1'b1, 1'b0, 3'd0, P_U};
      tbl[7]  = '{L_G,  1'b0, 1'b0, 3'd0, P_G};
      tbl[8]  = '{L_R,  1'b0, 1'b0, 3'd0, P_G};
      tbl[9]  = '{L_R,  1'b0, 1'b1, 3'd3, P_U};
      tbl[10] = '{L_R,  1'b1, 1'b0, 3'd0, P_U};
      tbl[11] = '{L_DK, 1'b1, 1'b0, 3'd0, P_U};
      tbl[12] = '{L_DK, 1'b0, 1'b0, 3'd0, P_U};
      tbl[13] = '{L_DK, 1'b0, 1'b0, 3'd0, P_U};
      tbl[14] = '{L_RG, 1'b0, 1'b0, 3'd0, P_U};
      tbl[15] = '{L_RG, 1'b1, 1'b0, 3'd0, P_U};
      tbl[16] = '{L_RG, 1'b0, 1'b1, 3'd1, P_U};
      tbl[17] = '{L_R,  1'b1, 1'b0, 3'd0, P_U};
      tbl[18] = '{L_R,  1'b0, 1'b0, 3'd0, P_R};
      tbl[19] = '{L_DK, 1'b0, 1'b0, 3'd0, P_R};
      tbl[20] = '{L_DK, 1'b0, 1'b1, 3'd2, P_U};
      tbl[21] = '{L_DK, 1'b1, 1'b0, 3'd0, P_U};

      // reset state, checked while reset is held
      #2;
      chk("reset_hold", 1'b0, 3'd0, P_U);
      chk_cc("reset_hold_cc", 8'd0);
      do_reset();

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].lamps, 1'b0, tbl[i].clr);
         tick();
         chk($sformatf("vec%0d", i), tbl[i].f, tbl[i].code, tbl[i].ph);
      end
      chk_cc("vec_cc", 8'd0);

      // legal G8/Y3/R6 x3 then back to green; phase trails input by one step
      do_reset();
      sched[0] = L_G; len[0] = 8;
      sched[1] = L_Y; len[1] = 3;
      sched[2] = L_R; len[2] = 6;
      prev = L_DK;
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < len[s]; k++) begin
               drive(sched[s], 1'b0, 1'b0);
               tick();
               chk($sformatf("legal_c%0d_s%0d_k%0d", c, s, k), 1'b0, 3'd0, ph_of(prev));
               prev = sched[s];
            end
         end
      end
      run(L_G, 1'b0, 3);
      chk("legal_end", 1'b0, 3'd0, P_G);
      chk_cc("legal_cc", 8'd3);

      // green dwell 2 -> SHORT_DWELL
      do_reset();
      run(L_R, 1'b0, 4);
      run(L_G, 1'b0, 2);
      run(L_Y, 1'b0, 2);
      chk("short_green", 1'b1, 3'd4, P_U);
      chk_cc("short_green_cc", 8'd1);

      // boundary: green 4, yellow 2 exactly at minimum
      do_reset();
      run(L_R, 1'b0, 4);
      run(L_G, 1'b0, 4);
      run(L_Y, 1'b0, 2);
      chk("min_green_ok", 1'b0, 3'd0, P_Y);
      run(L_R, 1'b0, 2);
      chk("min_yellow_ok", 1'b0, 3'd0, P_R);

      // emergency: short green straight to red is legal
      do_reset();
      run(L_R, 1'b0, 4);
      run(L_G, 1'b1, 2);
      run(L_R, 1'b1, 2);
      chk("emerg_g2r", 1'b0, 3'd0, P_R);

      // long red: dwell reaches 64 after 65 samples, fault on the next one
      do_reset();
      run(L_R, 1'b0, 65);
      chk("long_red_edge", 1'b0, 3'd0, P_R);
      run(L_R, 1'b0, 1);
      chk("long_red", 1'b1, 3'd5, P_U);
      run(L_R, 1'b0, 4);
      chk("long_red_sticky", 1'b1, 3'd5, P_U);

      do_reset();
      run(L_R, 1'b1, 70);
      chk("long_red_emerg", 1'b0, 3'd0, P_R);

      // async reset between edges mid-yellow
      do_reset();
      run(L_R, 1'b0, 4);
      run(L_G, 1'b0, 5);
      run(L_Y, 1'b0, 2);
      chk("pre_reset", 1'b0, 3'd0, P_Y);
      chk_cc("pre_reset_cc", 8'd1);
      #3;
      reset = 1'b0;
      #1;
      chk("async_reset", 1'b0, 3'd0, P_U);
      chk_cc("async_reset_cc", 8'd0);
      #2;
      reset = 1'b1;

`ifdef TL_MON_AUTOCLEAR_EN
      do_reset();
      run(L_G, 1'b0, 3);
      run(L_R, 1'b0, 2);
      chk("ac_fault", 1'b1, 3'd3, P_U);
      run(L_R, 1'b0, 3);
      chk("ac_wait", 1'b1, 3'd3, P_U);
      run(L_R, 1'b0, 1);
      chk("ac_release", 1'b0, 3'd3, P_R);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the lamp side of traffic_light. It samples red/yellow/green and emergency and tracks the phase sequence and per-phase dwell times. It flags illegal lamp patterns, illegal transitions and timing violations through a fault flag and code. It sits beside the controller in the integrated build and in benches, and drives nothing back into it.

Parameters:
MIN_GREEN, 4, minimum legal green dwell in clk cycles
YELLOW_MIN, 2, minimum legal yellow dwell
MIN_RED, 4, minimum legal red dwell
MAX_DWELL, 64, maximum dwell in any phase (emergency red exempt)
CNT_W, 8, width of dwell counter and cycle_count; all minimums and MAX_DWELL must be < 2**CNT_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
red  in  1  red lamp from controller
yellow  in  1  yellow lamp
green  in  1  green lamp
emergency  in  1  emergency override request seen by controller
clear_fault  in  1  synchronous pulse, clears fault
fault  out  1  sticky violation flag
fault_code  out  3  1 MULTI_LAMP, 2 DARK, 3 BAD_SEQ, 4 SHORT_DWELL, 5 LONG_DWELL; 0 none
phase  out  2  00 UNKNOWN, 01 RED, 10 YELLOW, 11 GREEN
cycle_count  out  CNT_W  completed RED->GREEN transitions, wraps at 2**CNT_W

Behaviour:
- Reset (async): state INIT, lamp_q=0, emerg_q=0, dwell=0, fault=0, fault_code=0, phase=00, cycle_count=0.
- Stage 1: {red,yellow,green,emergency} are registered into lamp_q/emerg_q. Stage 2: FSM evaluates lamp_q. fault/fault_code assert on the edge after the violating pattern is captured in lamp_q, 2 edges after the input change.
- States: INIT, RED, YELLOW, GREEN, FAULT. The phase output mirrors the state; INIT and FAULT drive 00.
- INIT: all-dark is tolerated. The first one-hot pattern enters the matching state with no sequence check and dwell=1. A multi-lamp pattern raises MULTI_LAMP.
- Legal transitions: GREEN->YELLOW, YELLOW->RED, RED->GREEN. When emerg_q=1, GREEN->RED is also legal.
- Dwell: set to 1 on phase entry. Increments each cycle the phase holds and saturates at all-ones.
- SHORT_DWELL: raised on a phase exit when dwell < that phase's minimum and emerg_q=0. The minimum is not checked when leaving for RED under emergency.
- LONG_DWELL: raised when dwell reaches MAX_DWELL while still in the phase. Suppressed when the state is RED and emerg_q=1.
- DARK: no lamp lit in RED, YELLOW or GREEN. MULTI_LAMP: more than one lamp lit in any state except FAULT.
- Priority when several violations occur in one cycle: MULTI_LAMP > DARK > BAD_SEQ > SHORT_DWELL > LONG_DWELL. Only the highest is recorded.
- Any violation: fault=1, fault_code latched, state FAULT. Checking is suspended and cycle_count is frozen.
- clear_fault: fault=0, fault_code=0, state INIT. If clear_fault coincides with a new violation, the clear wins; a persisting violation is re-detected from INIT.
- cycle_count increments on each legal RED->GREEN transition. It wraps from all-ones to 0 silently.
- Reset asserted mid-operation: everything returns to reset values immediately, regardless of clock.

Optional Feature:
TL_MON_AUTOCLEAR_EN
- Defined: FAULT keeps watching lamp_q. After MIN_RED consecutive cycles of a clean red-only pattern, fault deasserts and the state goes to RED with dwell=MIN_RED. fault_code keeps the last code until the next violation or clear_fault.
- Undefined: fault stays set until clear_fault or reset.

Decomposition:
- Package tl_pkg: lamp bit-position constants, phase encoding (PH_UNKNOWN/RED/YELLOW/GREEN), fault code constants, FSM state typedef.
- Sub-module tl_dwell_timer: saturating CNT_W counter with load-1 on phase change, plus comparators for the minimum and MAX_DWELL checks.

Test Plan:
- Legal cycle G8/Y3/R6 repeated 3 times, emergency=0 -> fault stays 0; cycle_count=3; phase follows the lamps 2 clocks late.
- green=1 and yellow=1 for one cycle during GREEN -> fault=1, fault_code=1 two edges later; phase=00.
- GREEN held 2 cycles then YELLOW -> fault_code=4; repeat with emergency=1 and GREEN->RED after 2 cycles -> no fault.
- RED held 70 cycles with emergency=0 -> fault_code=5 at dwell 64; same with emergency=1 -> no fault.
- GREEN->RED with emergency=0 -> fault_code=3. Then pulse clear_fault -> fault=0, code=0, state INIT. All lamps dark while in INIT -> no fault.
- Async reset low mid-YELLOW, between clock edges -> all outputs 0 immediately. With TL_MON_AUTOCLEAR_EN defined, a fault followed by 4 clean red cycles -> fault=0, phase=RED.
